mtr_drv_ramped: RTL and testbench
=================================

// Module: mtr_drv_ramped
// PURPOSE
//  NCH-channel successor to the dual motor driver. Per channel:
//   - signed speed command -> battery-compensated, saturated duty
//   - per-period slew limiting
//   - symmetric inversion, selectable by channel
//  All channels share one phase-aligned PWM counter. Each channel drives a
//  complementary H-bridge pair with dead-band. Sits between the PID/steering
//  stage and the bridge pins.
// PARAMETERS
//  NCH       2      number of motor channels
//  SPD_W     12     signed speed width; also PWM counter width (one width, W)
//  SLEW      64     max |cmd| change per PWM period; 0 = unlimited
//  DEAD      16     dead-band clocks between PWM1 and PWM2 edges
//  INV_MASK  2'b10  bit i=1 -> channel i direction inverted (right motor)
// PORTS
//  clk       in   1          system clock
//  rst_n     in   1          asynchronous active-low reset
//  en        in   1          0 = coast: all PWM low, slew state cleared
//  scale     in   13         unsigned battery scale Q2.11 (2048 = unity), from battery ROM
//  spd       in   NCH*SPD_W  packed signed speeds, channel i at [i*W +: W]
//  pwm1      out  NCH        high-side drive per channel
//  pwm2      out  NCH        low-side drive per channel
//  prd_strt  out  1          one-clk pulse when shared counter wraps to 0
// BEHAVIOUR
//  - Reset: cnt=0; spd_ff/prod_ff/tgt/cmd=0; pwm1=pwm2=0; prd_strt=0.
//  - Pipeline, per channel:
//    - C1: register spd.
//    - C2: prod = signed(spd_ff) * signed({0,scale}), SPD_W+14 bits, registered.
//    - C3: tgt = prod>>>11, saturated to [-(2^(W-1)-1), +(2^(W-1)-1)].
//      Symmetric clamp: -2^(W-1) is never produced, so inversion cannot overflow.
//  - Slew: cmd updates only on the cycle cnt wraps (max->0).
//    - cmd += clamp(tgt-cmd, -SLEW, +SLEW); SLEW=0 -> cmd=tgt.
//    - The difference is computed in W+1 bits.
//  - Duty: duty = 2^(W-1) + cmd, or 2^(W-1) - cmd if INV_MASK[i]. Range is [1, 2^W-1].
//  - Counter: free-running W-bit cnt, wraps 2^W-1 -> 0. prd_strt is registered and
//    high in the cycle cnt==0.
//  - Outputs, registered, computed in W+1 bits, no wrap:
//    - pwm1 = (cnt >= DEAD) && (cnt < duty)
//    - pwm2 = (cnt >= duty+DEAD)
//    - duty<=DEAD -> pwm1 never high. duty+DEAD >= 2^W -> pwm2 never high.
//    - pwm1 and pwm2 are never high together.
//  - Latency: spd change -> tgt valid 3 clks; cmd adopts at next wrap; pins change
//    1 clk after the compare.
//  - en=0 (sampled): next clk pwm1=pwm2=0 and cmd=0. Pipeline keeps running.
//    On en 0->1, cmd ramps from 0 starting at the next wrap.
//  - Simultaneous wrap + en=0: en wins, cmd=0.
//  - scale=0 -> tgt=0, duty=2^(W-1) (50/50, zero net drive).
//  - Async reset mid-period: all state cleared immediately; counting restarts from 0.
// STRUCTURE
//  - Package mtr_drv_pkg:
//    - SCALE_FRAC=11, SCALE_W=13
//    - function sat_sym(val, W)
//    - function slew_step(tgt, cur, SLEW)
//  - Sub-module pwm_dual_dead (params W, DEAD):
//    - in: cnt, duty
//    - out: pwm1, pwm2
//    - one instance per channel via generate
//  - Counter, pipeline and slew logic live in the top.
// TESTING (defaults, W=12, period 4096 clks)
//  1. Reset, then hold: all pwm 0, prd_strt 0.
//     Release: prd_strt pulses every 4096 clks.
//  2. SLEW=0, scale=2048, spd0=+400, en=1 -> duty0=0x990.
//     - pwm1 high 2432 clks/period, pwm2 high 1632.
//     - ch1 same spd, inverted -> duty1=0x670.
//  3. scale=8191, spd0=+2047 -> tgt clamps 2047 -> duty0=4095, duty1(inv)=1.
//     - spd0=-2048 -> duty0=1; ch1 pwm1 never high.
//  4. SLEW=64, scale=2048, spd0 0->1000 -> cmd 64,128,...,960 then 1000 at the 16th wrap.
//     - pwm1 width grows monotonically.
//  5. en=0 mid-ramp (cmd=512) -> both pins low next clk.
//     - en=1 -> first wrap cmd=64.
//  6. rst_n low at cnt=1000 with pwm1 high -> pins 0 same clk.
//     - After release, cnt=0 and the ramp restarts from 0.

Source files
------------

// File: rtl/mtr_drv_pkg.sv
`default_nettype none
// mtr_drv_pkg: shared constants and saturating/slew helpers for the ramped motor driver.
package mtr_drv_pkg;

  localparam int SCALE_FRAC = 11;
  localparam int SCALE_W    = 13;

  // Symmetric clamp to +/-(2^(w-1)-1); the most negative code is never returned.
  function automatic logic signed [31:0] sat_sym(input logic signed [31:0] val, input int w);
    logic signed [31:0] lim;
    lim = (32'sd1 <<< (w - 1)) - 32'sd1;
    if (val > lim) return lim;
    if (val < -lim) return -lim;
    return val;
  endfunction

  function automatic logic signed [31:0] slew_step(input logic signed [31:0] tgt,
                                                   input logic signed [31:0] cur,
                                                   input int slew);
    logic signed [31:0] diff;
    logic signed [31:0] lim;
    diff = tgt - cur;
    lim  = slew;
    if (slew == 0) return tgt;
    if (diff > lim) diff = lim;
    else if (diff < -lim) diff = -lim;
    return cur + diff;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pwm_dual_dead.sv
`default_nettype none
// pwm_dual_dead: complementary high/low-side compare with dead-band, evaluated in W+1 bits.
module pwm_dual_dead #(
  parameter int W    = 12,
  parameter int DEAD = 16
) (
  input  logic [W-1:0] cnt_i,
  input  logic [W-1:0] duty_i,
  output logic         pwm1_o,
  output logic         pwm2_o
);

  logic [W:0] cnt_x;
  logic [W:0] duty_x;
  logic [W:0] dead_x;

  always_comb begin
    cnt_x  = {1'b0, cnt_i};
    duty_x = {1'b0, duty_i};
    dead_x = (W+1)'(DEAD);
    pwm1_o = (cnt_x >= dead_x) && (cnt_x < duty_x);
    pwm2_o = (cnt_x >= (duty_x + dead_x));
  end

endmodule
`default_nettype wire

// File: rtl/mtr_drv_ramped.sv
`default_nettype none
// mtr_drv_ramped: NCH-channel battery-compensated, slew-limited H-bridge PWM driver
// sharing one phase-aligned period counter.
module mtr_drv_ramped
  import mtr_drv_pkg::*;
#(
  parameter int             NCH      = 2,
  parameter int             SPD_W    = 12,
  parameter int             SLEW     = 64,
  parameter int             DEAD     = 16,
  parameter logic [NCH-1:0] INV_MASK = NCH'(2'b10)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic [SCALE_W-1:0]     scale,
  input  logic [NCH*SPD_W-1:0]   spd,
  output logic [NCH-1:0]         pwm1,
  output logic [NCH-1:0]         pwm2,
  output logic                   prd_strt
);

  localparam int             W       = SPD_W;
  localparam int             PW      = W + SCALE_W + 1;
  localparam logic [W-1:0]   CNT_MAX = '1;
  localparam logic [W:0]     HALF    = {2'b01, {(W-1){1'b0}}};

  logic [W-1:0] cnt_q, cnt_d;
  logic         prd_q, prd_d;
  logic         wrap;

  always_comb begin
    wrap  = (cnt_q == CNT_MAX);
    cnt_d = cnt_q + W'(1);
    prd_d = wrap;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      prd_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      prd_q <= prd_d;
    end
  end

  assign prd_strt = prd_q;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic signed [W-1:0]  spd_q;
    logic signed [PW-1:0] prod_q, prod_d, prod_sh;
    logic signed [W-1:0]  tgt_q, tgt_d;
    logic signed [W-1:0]  cmd_q, cmd_d;
    logic signed [31:0]   sat_w, step_w;
    logic signed [W:0]    duty_x;
    logic [W-1:0]         duty;
    logic                 p1_w, p2_w;
    logic                 p1_q, p2_q;
    logic                 unused_bits;

    always_comb begin
      prod_d  = PW'(spd_q) * PW'($signed({1'b0, scale}));
      prod_sh = prod_q >>> SCALE_FRAC;
      sat_w   = sat_sym(32'(prod_sh), W);
      tgt_d   = sat_w[W-1:0];
      step_w  = slew_step(32'(tgt_q), 32'(cmd_q), SLEW);
      // Coast has priority over a coincident wrap so the ramp always restarts at 0.
      cmd_d   = cmd_q;
      if (!en)
        cmd_d = '0;
      else if (wrap)
        cmd_d = step_w[W-1:0];
      if (INV_MASK[i])
        duty_x = $signed(HALF) - (W+1)'(cmd_q);
      else
        duty_x = $signed(HALF) + (W+1)'(cmd_q);
      duty = duty_x[W-1:0];
    end

    assign unused_bits = ^{sat_w[31:W], step_w[31:W], duty_x[W]};

    pwm_dual_dead #(
      .W    (W),
      .DEAD (DEAD)
    ) u_pwm (
      .cnt_i  (cnt_q),
      .duty_i (duty),
      .pwm1_o (p1_w),
      .pwm2_o (p2_w)
    );

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        spd_q  <= '0;
        prod_q <= '0;
        tgt_q  <= '0;
        cmd_q  <= '0;
        p1_q   <= 1'b0;
        p2_q   <= 1'b0;
      end else begin
        spd_q  <= spd[i*W +: W];
        prod_q <= prod_d;
        tgt_q  <= tgt_d;
        cmd_q  <= cmd_d;
        p1_q   <= en & p1_w;
        p2_q   <= en & p2_w;
      end
    end

    assign pwm1[i] = p1_q;
    assign pwm2[i] = p2_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_mtr_drv_ramped.sv
`default_nettype none
// tb_mtr_drv_ramped: directed vectors and ramp/coast/reset sequences on three driver instances.
module tb_mtr_drv_ramped;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n0 = 1'b0, rst_n1 = 1'b0, rst_n2 = 1'b0;
  logic        en0 = 1'b0, en1 = 1'b0, en2 = 1'b0;
  logic [12:0] scale0 = '0, scale1 = '0, scale2 = '0;
  logic [23:0] spd0 = '0, spd1 = '0, spd2 = '0;
  logic [1:0]  pwm1_0, pwm2_0, pwm1_1, pwm2_1, pwm1_2, pwm2_2;
  logic        prd0, prd1, prd2;

  int errors = 0;
  int checks = 0;

  // dut0: no slew limit, used for steady-state duty vectors
  mtr_drv_ramped #(.SLEW(0)) dut0 (
    .clk(clk), .rst_n(rst_n0), .en(en0), .scale(scale0), .spd(spd0),
    .pwm1(pwm1_0), .pwm2(pwm2_0), .prd_strt(prd0));
  // dut1: slew-limited ramp
  mtr_drv_ramped #(.SLEW(64)) dut1 (
    .clk(clk), .rst_n(rst_n1), .en(en1), .scale(scale1), .spd(spd1),
    .pwm1(pwm1_1), .pwm2(pwm2_1), .prd_strt(prd1));
  // dut2: coast and mid-period reset sequences
  mtr_drv_ramped #(.SLEW(64)) dut2 (
    .clk(clk), .rst_n(rst_n2), .en(en2), .scale(scale2), .spd(spd2),
    .pwm1(pwm1_2), .pwm2(pwm2_2), .prd_strt(prd2));

  typedef struct {
    logic signed [11:0] s0;
    logic signed [11:0] s1;
    logic [12:0]        sc;
    int                 p1a, p2a, p1b, p2b;
  } vec_t;

  vec_t vt[6];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic prd_of(input int d);
    case (d)
      0:       return prd0;
      1:       return prd1;
      default: return prd2;
    endcase
  endfunction

  function automatic logic [1:0] p1_of(input int d);
    case (d)
      0:       return pwm1_0;
      1:       return pwm1_1;
      default: return pwm1_2;
    endcase
  endfunction

  function automatic logic [1:0] p2_of(input int d);
    case (d)
      0:       return pwm2_0;
      1:       return pwm2_1;
      default: return pwm2_2;
    endcase
  endfunction

  task automatic wait_prd(input int d, output int n);
    n = 0;
    forever begin
      @(negedge clk);
      n++;
      if (prd_of(d)) break;
      if (n >= 5000) begin
        checks++;
        errors++;
        $display("FAIL prd_timeout dut%0d: no pulse after %0d clks, expected within 4096", d, n);
        break;
      end
    end
  endtask

  // One full period of high-time counts per channel, plus overlap count.
  task automatic measure(input int d, output int a1, output int a2,
                         output int b1, output int b2, output int ov);
    logic [1:0] p1, p2;
    a1 = 0; a2 = 0; b1 = 0; b2 = 0; ov = 0;
    for (int c = 0; c < 4096; c++) begin
      @(negedge clk);
      p1 = p1_of(d);
      p2 = p2_of(d);
      a1 += int'(p1[0]);
      a2 += int'(p2[0]);
      b1 += int'(p1[1]);
      b2 += int'(p2[1]);
      ov += int'(|(p1 & p2));
    end
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    //         s0     s1    scale  p1c0  p2c0  p1c1  p2c1
    vt[0] = '{ 12'sd400,   12'sd400,   13'd2048, 2432, 1632, 1632, 2432};
    vt[1] = '{ 12'sd2047,  12'sd2047,  13'd8191, 4079,    0,    0, 4079};
    vt[2] = '{-12'sd2048, -12'sd2048,  13'd8191,    0, 4079, 4079,    0};
    vt[3] = '{ 12'sd1000, -12'sd300,   13'd0,    2032, 2032, 2032, 2032};
    vt[4] = '{-12'sd1000,  12'sd500,   13'd1024, 1532, 2532, 1782, 2282};
    vt[5] = '{ 12'sd3,    -12'sd3,     13'd3000, 2036, 2028, 2037, 2027};

    fork
      begin : proc_vec
        int n, a1, a2, b1, b2, ov;
        en0 = 1'b1;
        scale0 = vt[0].sc;
        spd0 = {vt[0].s1, vt[0].s0};
        repeat (3) @(negedge clk);
        check("rst_pwm1", int'(pwm1_0), 0);
        check("rst_pwm2", int'(pwm2_0), 0);
        check("rst_prd", int'(prd0), 0);
        rst_n0 = 1'b1;
        wait_prd(0, n);
        check("first_prd_clks", n, 4096);
        wait_prd(0, n);
        check("prd_interval", n, 4096);
        for (int v = 0; v < 6; v++) begin
          scale0 = vt[v].sc;
          spd0 = {vt[v].s1, vt[v].s0};
          wait_prd(0, n);
          measure(0, a1, a2, b1, b2, ov);
          check($sformatf("v%0d_c0_pwm1_hi", v), a1, vt[v].p1a);
          check($sformatf("v%0d_c0_pwm2_hi", v), a2, vt[v].p2a);
          check($sformatf("v%0d_c1_pwm1_hi", v), b1, vt[v].p1b);
          check($sformatf("v%0d_c1_pwm2_hi", v), b2, vt[v].p2b);
          check($sformatf("v%0d_overlap", v), ov, 0);
        end
      end
      begin : proc_ramp
        int n, a1, a2, b1, b2, ov, cmd;
        en1 = 1'b1;
        scale1 = 13'd2048;
        spd1 = {12'sd1000, 12'sd1000};
        repeat (3) @(negedge clk);
        rst_n1 = 1'b1;
        wait_prd(1, n);
        for (int k = 1; k <= 16; k++) begin
          cmd = (64 * k > 1000) ? 1000 : 64 * k;
          measure(1, a1, a2, b1, b2, ov);
          check($sformatf("ramp%0d_c0_pwm1_hi", k), a1, 2032 + cmd);
          check($sformatf("ramp%0d_c1_pwm1_hi", k), b1, 2032 - cmd);
        end
      end
      begin : proc_seq
        int n, a1, a2, b1, b2, ov;
        en2 = 1'b1;
        scale2 = 13'd2048;
        spd2 = {12'sd600, 12'sd600};
        repeat (3) @(negedge clk);
        check("seq_rst_pwm1", int'(pwm1_2), 0);
        check("seq_rst_pwm2", int'(pwm2_2), 0);
        rst_n2 = 1'b1;
        repeat (8) wait_prd(2, n);
        repeat (100) @(negedge clk);
        check("pre_coast_pwm1", int'(pwm1_2), 3);
        en2 = 1'b0;
        @(negedge clk);
        check("coast_pwm1", int'(pwm1_2), 0);
        check("coast_pwm2", int'(pwm2_2), 0);
        repeat (10) @(negedge clk);
        en2 = 1'b1;
        wait_prd(2, n);
        measure(2, a1, a2, b1, b2, ov);
        check("reen_c0_pwm1_hi", a1, 2096);
        check("reen_c1_pwm1_hi", b1, 1968);
        repeat (1000) @(negedge clk);
        check("pre_rst_pwm1", int'(pwm1_2), 3);
        rst_n2 = 1'b0;
        #1;
        check("async_rst_pwm1", int'(pwm1_2), 0);
        check("async_rst_pwm2", int'(pwm2_2), 0);
        check("async_rst_prd", int'(prd2), 0);
        repeat (2) @(negedge clk);
        rst_n2 = 1'b1;
        wait_prd(2, n);
        check("post_rst_prd_clks", n, 4096);
        measure(2, a1, a2, b1, b2, ov);
        check("post_rst_c0_pwm1_hi", a1, 2096);
        check("post_rst_overlap", ov, 0);
      end
    join

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
